change_dispenser: RTL and testbench

Sequential coin-return engine between the vending machine's money register and the physical coin hopper. On a return request it captures the current balance and pays it out greedily, largest coin first, one coin per valid/ready handshake. Any number of coins of each value may be paid. It reports the remaining balance, the number of coins paid, and any residue too small for the smallest coin.

---
 rtl/change_dispenser.sv | 124 ++++++++++++
 tb/tb_change_dispenser.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin-return engine: captures a balance on request and pays it out largest coin first,
// one coin per valid/ready handshake, then reports any residue below the smallest coin.
module change_dispenser #(
  parameter int unsigned kTotalBits   = 31,
  parameter int unsigned kNumCoins    = 3,
  parameter int unsigned COIN_VALUE_0 = 100,
  parameter int unsigned COIN_VALUE_1 = 500,
  parameter int unsigned COIN_VALUE_2 = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [kTotalBits-1:0] i_balance,
  input  logic                  i_coin_ready,
  output logic                  o_busy,
  output logic                  o_coin_valid,
  output logic [kNumCoins-1:0]  o_coin,
  output logic [kTotalBits-1:0] o_remaining,
  output logic [15:0]           o_coin_count,
  output logic [kTotalBits-1:0] o_residue,
  output logic                  o_done
);

  localparam logic [kTotalBits-1:0] kValue0 = kTotalBits'(COIN_VALUE_0);
  localparam logic [kTotalBits-1:0] kValue1 = kTotalBits'(COIN_VALUE_1);
  localparam logic [kTotalBits-1:0] kValue2 = kTotalBits'(COIN_VALUE_2);

  typedef enum logic [1:0] {StIdle, StSelect, StOffer, StDone} state_e;

  state_e                  r_state, w_state_next;
  logic [kNumCoins-1:0]    r_coin;
  logic [kTotalBits-1:0]   r_remaining;
  logic [kTotalBits-1:0]   r_residue;
  logic [15:0]             r_count;

  logic [kNumCoins-1:0]    w_pick;
  logic [kTotalBits-1:0]   w_coin_value;
  logic [15:0]             w_count_inc;

  // Highest coin that still fits in the remaining balance; zero when nothing fits.
  always_comb begin
    w_pick = '0;
    if (r_remaining >= kValue2) begin
      w_pick[2] = 1'b1;
    end else if (r_remaining >= kValue1) begin
      w_pick[1] = 1'b1;
    end else if (r_remaining >= kValue0) begin
      w_pick[0] = 1'b1;
    end
  end

  always_comb begin
    w_coin_value = '0;
    if (r_coin[2]) begin
      w_coin_value = kValue2;
    end else if (r_coin[1]) begin
      w_coin_value = kValue1;
    end else if (r_coin[0]) begin
      w_coin_value = kValue0;
    end
  end

  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_next = StSelect;
      StSelect: w_state_next = (w_pick != '0) ? StOffer : StDone;
      StOffer:  if (i_coin_ready) w_state_next = StSelect;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Datapath; a coin on offer when reset hits is dropped without being counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_coin      <= '0;
      r_remaining <= '0;
      r_residue   <= '0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_remaining <= i_balance;
            r_count     <= '0;
            r_residue   <= '0;
          end
        end
        StSelect: r_coin <= w_pick;
        StOffer: begin
          if (i_coin_ready) begin
            r_remaining <= r_remaining - w_coin_value;
            r_count     <= w_count_inc;
            r_coin      <= '0;
          end
        end
        StDone:   r_residue <= r_remaining;
        default:  r_coin <= '0;
      endcase
    end
  end

  always_comb begin
    o_busy       = (r_state != StIdle);
    o_coin_valid = (r_state == StOffer);
    o_done       = (r_state == StDone);
    o_coin       = r_coin;
    o_remaining  = r_remaining;
    o_coin_count = r_count;
    o_residue    = r_residue;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: transaction-level greedy payout model compared every cycle,
// directed timing/literal checks, then randomized starts, backpressure and resets.
module tb_change_dispenser;
  localparam int unsigned W = 31;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start;
  logic [W-1:0]  i_balance;
  logic          i_coin_ready;
  logic          o_busy;
  logic          o_coin_valid;
  logic [2:0]    o_coin;
  logic [W-1:0]  o_remaining;
  logic [15:0]   o_coin_count;
  logic [W-1:0]  o_residue;
  logic          o_done;

  change_dispenser dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_balance    (i_balance),
    .i_coin_ready (i_coin_ready),
    .o_busy       (o_busy),
    .o_coin_valid (o_coin_valid),
    .o_coin       (o_coin),
    .o_remaining  (o_remaining),
    .o_coin_count (o_coin_count),
    .o_residue    (o_residue),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at edge %0d", name, act, act, exp,
               exp, cyc);
    end
  endtask

  function automatic logic [2:0] onehot(input int unsigned v);
    return (v == 1000) ? 3'b100 : (v == 500) ? 3'b010 : 3'b001;
  endfunction

  // Model: a transaction is a queue of coins from division-based greedy change; each coin takes a
  // decision slot then an offer slot held until accepted; a closing slot reports the residue.
  int            m_slot = 0;  // 0 idle, 1 decide, 2 offer, 3 done
  logic [W-1:0]  m_rem  = '0;
  logic [W-1:0]  m_res  = '0;
  logic [15:0]   m_cnt  = '0;
  int unsigned   m_q[$];

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_slot = 0;
      m_rem  = '0;
      m_res  = '0;
      m_cnt  = '0;
      m_q.delete();
    end else begin
      case (m_slot)
        0: if (i_start) begin
          int unsigned b;
          b = 32'(i_balance);
          m_rem = i_balance;
          m_cnt = '0;
          m_res = '0;
          m_q.delete();
          for (int i = 0; i < int'(b / 1000); i++) m_q.push_back(1000);
          b = b % 1000;
          for (int i = 0; i < int'(b / 500); i++) m_q.push_back(500);
          b = b % 500;
          for (int i = 0; i < int'(b / 100); i++) m_q.push_back(100);
          m_slot = 1;
        end
        1: m_slot = (m_q.size() != 0) ? 2 : 3;
        2: if (i_coin_ready) begin
          int unsigned v;
          v = m_q.pop_front();
          m_rem = m_rem - W'(v);
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          m_slot = 1;
        end
        3: begin
          m_res  = m_rem;
          m_slot = 0;
        end
        default: m_slot = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", 32'(o_busy), 32'(m_slot != 0));
      check("coin_valid", 32'(o_coin_valid), 32'(m_slot == 2));
      check("coin", 32'(o_coin), 32'((m_slot == 2) ? onehot(m_q[0]) : 3'b000));
      check("done", 32'(o_done), 32'(m_slot == 3));
      check("remaining", 32'(o_remaining), 32'(m_rem));
      check("coin_count", 32'(o_coin_count), 32'(m_cnt));
      check("residue", 32'(o_residue), 32'(m_res));
    end
  end

  int          lg_cyc[$];
  logic [2:0]  lg_coin[$];

  // Runs one transaction from IDLE. Cycle numbering: edge k accepts start, cycle k+1 follows it.
  task automatic run(input logic [W-1:0] bal, input int stall, input int poke,
                     output int k, output int dc);
    int stalled;
    stalled = 0;
    dc = -1;
    lg_cyc.delete();
    lg_coin.delete();
    @(negedge clk);
    i_start = 1'b1;
    i_balance = bal;
    i_coin_ready = 1'b1;
    @(negedge clk);
    k = cyc;
    for (int n = 0; n < 200; n++) begin
      i_start = (n == poke);
      if (n == poke) i_balance = 31'd9999;
      if (o_coin_valid) begin
        if (stalled < stall) begin
          i_coin_ready = 1'b0;
          stalled = stalled + 1;
          check("stall_coin", 32'(o_coin), 32'h2);
          check("stall_remaining", 32'(o_remaining), 32'd500);
        end else begin
          i_coin_ready = 1'b1;
          lg_cyc.push_back(cyc + 1);
          lg_coin.push_back(o_coin);
        end
      end
      if (o_done) begin
        dc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    if (dc < 0) check("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_totals(input string tag, input int cnt, input int res, input int rem);
    check({tag, "_count"}, 32'(o_coin_count), 32'(cnt));
    check({tag, "_residue"}, 32'(o_residue), 32'(res));
    check({tag, "_remaining"}, 32'(o_remaining), 32'(rem));
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int k;
    int dc;
    logic [W-1:0] bal;
    reset_n = 1'b0;
    i_start = 1'b1;
    i_balance = 31'd1234;
    i_coin_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_outputs", 32'(o_coin_valid) | 32'(o_done) | 32'(o_coin) | 32'(o_remaining) |
          32'(o_coin_count) | 32'(o_residue), 32'd0);
    i_start = 1'b0;
    reset_n = 1'b1;

    run(31'd1600, 0, -1, k, dc);
    check("mix_n", 32'(lg_cyc.size()), 32'd3);
    if (lg_cyc.size() == 3) begin
      check("mix_c0", 32'(lg_cyc[0] - k), 32'd2);
      check("mix_c1", 32'(lg_cyc[1] - k), 32'd4);
      check("mix_c2", 32'(lg_cyc[2] - k), 32'd6);
      check("mix_v0", 32'(lg_coin[0]), 32'h4);
      check("mix_v1", 32'(lg_coin[1]), 32'h2);
      check("mix_v2", 32'(lg_coin[2]), 32'h1);
    end
    check("mix_done_cycle", 32'(dc - k), 32'd8);
    check_totals("mix", 3, 0, 0);

    run(31'd2250, 0, -1, k, dc);
    check("rep_done_cycle", 32'(dc - k), 32'd10);
    check_totals("rep", 4, 50, 50);

    run(31'd500, 5, -1, k, dc);
    check("bp_done_cycle", 32'(dc - k), 32'd9);
    check_totals("bp", 1, 0, 0);

    run(31'd0, 0, -1, k, dc);
    check("zero_coins", 32'(lg_cyc.size()), 32'd0);
    check("zero_done_cycle", 32'(dc - k), 32'd2);
    check_totals("zero", 0, 0, 0);

    run(31'd1600, 0, 3, k, dc);
    check("poke_done_cycle", 32'(dc - k), 32'd8);
    check_totals("poke", 3, 0, 0);

    // Reset while a coin sits on offer.
    @(negedge clk);
    i_start = 1'b1;
    i_balance = 31'd1600;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 0; n < 20 && !o_coin_valid; n++) @(negedge clk);
    check("rst_mid_offer_reached", 32'(o_coin_valid), 32'd1);
    i_coin_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 32'(o_busy) | 32'(o_coin_valid) | 32'(o_done) | 32'(o_coin) |
          32'(o_remaining) | 32'(o_coin_count) | 32'(o_residue), 32'd0);
    reset_n = 1'b1;
    run(31'd100, 0, -1, k, dc);
    check("after_rst_done_cycle", 32'(dc - k), 32'd4);
    check_totals("after_rst", 1, 0, 0);

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 299) != 0);
      i_start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       bal = W'($urandom_range(0, 99));
        1:       bal = W'($urandom_range(0, 3000));
        default: bal = W'($urandom_range(0, 20000));
      endcase
      i_balance = bal;
      i_coin_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    i_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
